// File: rtl/mlb_row_loader.sv
// Write-side MLB feeder: packs LANES consecutive stream words into one MLB row
// and issues one row write per packed row, stepping mlb_sel_pe upward from 0.
module mlb_row_loader #(
    parameter int DATA_W = 32,
    parameter int LANES  = 16,
    parameter int ROWS   = 32,
    parameter int ROW_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ROW_W:0]            num_rows,
    input  logic                      abort,
    input  logic                      s_valid,
    input  logic [DATA_W-1:0]         s_data,
    output logic                      s_ready,
    output logic                      mlb_write_en,
    output logic                      mlb_read_en,
    output logic [ROW_W-1:0]          mlb_sel_pe,
    output logic [LANES*DATA_W-1:0]   mlb_data,
    output logic                      busy,
    output logic                      done
);

    localparam int LANE_W = $clog2(LANES);
    localparam logic [ROW_W:0] MAX_ROWS = (ROW_W+1)'(ROWS);
    localparam logic [ROW_W:0] ONE_ROW  = (ROW_W+1)'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state, state_nxt;
    logic [ROW_W:0]          num_rows_q;
    logic [ROW_W-1:0]        row_cnt;
    logic [LANE_W-1:0]       word_cnt;
    logic [LANES*DATA_W-1:0] row_buf, row_nxt;
    logic                    accept, last_word, last_row, job_abort;

    assign accept    = s_valid & s_ready;
    assign last_word = (word_cnt == LANE_W'(LANES - 1));
    assign last_row  = ({1'b0, row_cnt} == (num_rows_q - ONE_ROW));
    assign job_abort = abort & (state != S_IDLE);

    assign mlb_read_en = 1'b0;

    // Row being assembled with the current word dropped into its lane.
    always_comb begin
        row_nxt = row_buf;
        for (int k = 0; k < LANES; k++) begin
            if (word_cnt == LANE_W'(k))
                row_nxt[k*DATA_W +: DATA_W] = s_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (num_rows == '0) ? S_DONE : S_FILL;
            S_FILL:  if (accept && last_word) state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_row ? S_DONE : S_FILL;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (job_abort)
            state_nxt = S_IDLE;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
            mlb_write_en <= 1'b0;
            done         <= 1'b0;
            mlb_sel_pe   <= '0;
            mlb_data     <= '0;
            num_rows_q   <= '0;
            row_cnt      <= '0;
            word_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            s_ready      <= (state_nxt == S_FILL);
            busy         <= (state_nxt == S_FILL) || (state_nxt == S_WRITE);
            mlb_write_en <= (state_nxt == S_WRITE);
            done         <= (state == S_DONE) && !abort;
            if (job_abort) begin
                row_cnt  <= '0;
                word_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            num_rows_q <= (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
                            row_cnt    <= '0;
                            word_cnt   <= '0;
                        end
                    end
                    S_FILL: begin
                        if (accept) begin
                            word_cnt <= word_cnt + 1'b1;
                            if (last_word) begin
                                mlb_data   <= row_nxt;
                                mlb_sel_pe <= row_cnt;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (!last_row) begin
                            row_cnt  <= row_cnt + 1'b1;
                            word_cnt <= '0;
                        end
                    end
                    S_DONE:  row_cnt <= '0;
                    default: ;
                endcase
            end
        end
    end

    // Lane storage needs no reset: every lane is rewritten before a row is issued.
    always_ff @(posedge clk) begin
        if (accept)
            row_buf <= row_nxt;
    end

endmodule
